// File: rtl/dice_score_keeper.sv
// N-player dice roll and score engine: synchronised roll keys sample free-running die
// counters into saturating scores, with target detection, winner/tie and optional turns.
module dice_score_keeper #(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 8,
  parameter int TARGET      = 100,
  parameter int DIE_FACES   = 6,
  parameter int TURN_MODE   = 0,
  localparam int PW         = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start_n,
  input  logic [NUM_PLAYERS-1:0]         roll_n,
  output logic [3*NUM_PLAYERS-1:0]       face,
  output logic [NUM_PLAYERS-1:0]         face_valid,
  output logic [SCORE_W*NUM_PLAYERS-1:0] scores,
  output logic [PW-1:0]                  turn,
  output logic [NUM_PLAYERS-1:0]         illegal_roll,
  output logic                           game_over,
  output logic [PW-1:0]                  winner,
  output logic                           tie
);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DONE = 2'd2} state_t;

  localparam int                 SW1         = SCORE_W + 1;
  localparam logic [SCORE_W-1:0] TARGET_V    = SCORE_W'(TARGET);
  localparam logic [SCORE_W-1:0] SAT_MAX     = {SCORE_W{1'b1}};
  localparam logic [2:0]         FACE_MAX    = 3'(DIE_FACES);
  localparam logic [PW-1:0]      LAST_PLAYER = PW'(NUM_PLAYERS - 1);

  state_t                         state_r, state_nxt_s;
  logic                           start_sync1_r, start_sync2_r, start_dly_r, start_press_s;
  logic [NUM_PLAYERS-1:0]         roll_sync1_r, roll_sync2_r, roll_dly_r, roll_press_s;
  logic [NUM_PLAYERS-1:0][2:0]    die_r;
  logic [3*NUM_PLAYERS-1:0]       face_r, face_nxt_s;
  logic [NUM_PLAYERS-1:0]         face_valid_r, face_valid_nxt_s;
  logic [SCORE_W*NUM_PLAYERS-1:0] scores_r, scores_nxt_s;
  logic [PW-1:0]                  turn_r, turn_nxt_s;
  logic [NUM_PLAYERS-1:0]         illegal_r, illegal_nxt_s;
  logic                           game_over_r, game_over_nxt_s;
  logic [PW-1:0]                  winner_r, winner_nxt_s;
  logic                           tie_r, tie_nxt_s;
  logic [NUM_PLAYERS-1:0]         accept_s, hit_s;
  logic [SCORE_W:0]               sum_s;
  logic [SCORE_W-1:0]             sat_s;
  logic [3:0]                     hit_cnt_s;
  logic [PW-1:0]                  win_sel_s;

  // A press is the synchronised falling edge; holding the key gives only one.
  assign start_press_s = start_dly_r & ~start_sync2_r;
  assign roll_press_s  = roll_dly_r & ~roll_sync2_r;

  // Two-flop synchronisers plus edge-detect delay, idling at the released level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_sync1_r <= 1'b1;
      start_sync2_r <= 1'b1;
      start_dly_r   <= 1'b1;
      roll_sync1_r  <= '1;
      roll_sync2_r  <= '1;
      roll_dly_r    <= '1;
    end else begin
      start_sync1_r <= start_n;
      start_sync2_r <= start_sync1_r;
      start_dly_r   <= start_sync2_r;
      roll_sync1_r  <= roll_n;
      roll_sync2_r  <= roll_sync1_r;
      roll_dly_r    <= roll_sync2_r;
    end
  end

  // Free-running per-player die counters cycling 1..DIE_FACES
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      die_r <= {NUM_PLAYERS{3'd1}};
    end else begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        die_r[i] <= (die_r[i] == FACE_MAX) ? 3'd1 : die_r[i] + 3'd1;
      end
    end
  end

  // Next-state and next-output logic for the game FSM
  always_comb begin
    state_nxt_s      = state_r;
    face_nxt_s       = face_r;
    face_valid_nxt_s = '0;
    scores_nxt_s     = scores_r;
    turn_nxt_s       = turn_r;
    illegal_nxt_s    = '0;
    game_over_nxt_s  = game_over_r;
    winner_nxt_s     = winner_r;
    tie_nxt_s        = tie_r;
    accept_s         = '0;
    hit_s            = '0;
    sum_s            = '0;
    sat_s            = '0;
    hit_cnt_s        = 4'd0;
    win_sel_s        = '0;
    if (start_press_s) begin
      // A start press always opens a fresh game; a roll in the same cycle is dropped.
      state_nxt_s     = PLAY;
      face_nxt_s      = '0;
      scores_nxt_s    = '0;
      turn_nxt_s      = '0;
      game_over_nxt_s = 1'b0;
      winner_nxt_s    = '0;
      tie_nxt_s       = 1'b0;
    end else begin
      case (state_r)
        IDLE: state_nxt_s = IDLE;
        PLAY: begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            accept_s[i]      = roll_press_s[i] & ((TURN_MODE == 0) | (turn_r == PW'(i)));
            illegal_nxt_s[i] = roll_press_s[i] & ~accept_s[i];
            sum_s = {1'b0, scores_r[SCORE_W*i +: SCORE_W]} + SW1'(die_r[i]);
            sat_s = sum_s[SCORE_W] ? SAT_MAX : sum_s[SCORE_W-1:0];
            face_nxt_s[3*i +: 3] = accept_s[i] ? die_r[i] : face_r[3*i +: 3];
            scores_nxt_s[SCORE_W*i +: SCORE_W] =
              accept_s[i] ? sat_s : scores_r[SCORE_W*i +: SCORE_W];
            hit_s[i] = accept_s[i] & (sat_s >= TARGET_V);
          end
          face_valid_nxt_s = accept_s;
          for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            win_sel_s = hit_s[i] ? PW'(i) : win_sel_s;
            hit_cnt_s = hit_cnt_s + {3'd0, hit_s[i]};
          end
          if ((TURN_MODE != 0) && (|accept_s)) begin
            turn_nxt_s = (turn_r == LAST_PLAYER) ? '0 : turn_r + PW'(1);
          end else begin
            turn_nxt_s = turn_r;
          end
          if (|hit_s) begin
            state_nxt_s     = DONE;
            game_over_nxt_s = 1'b1;
            winner_nxt_s    = win_sel_s;
            tie_nxt_s       = (hit_cnt_s > 4'd1);
          end else begin
            state_nxt_s = PLAY;
          end
        end
        DONE:    state_nxt_s = DONE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      face_r       <= '0;
      face_valid_r <= '0;
      scores_r     <= '0;
      turn_r       <= '0;
      illegal_r    <= '0;
      game_over_r  <= 1'b0;
      winner_r     <= '0;
      tie_r        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      face_r       <= face_nxt_s;
      face_valid_r <= face_valid_nxt_s;
      scores_r     <= scores_nxt_s;
      turn_r       <= turn_nxt_s;
      illegal_r    <= illegal_nxt_s;
      game_over_r  <= game_over_nxt_s;
      winner_r     <= winner_nxt_s;
      tie_r        <= tie_nxt_s;
    end
  end

  assign face         = face_r;
  assign face_valid   = face_valid_r;
  assign scores       = scores_r;
  assign turn         = turn_r;
  assign illegal_roll = illegal_r;
  assign game_over    = game_over_r;
  assign winner       = winner_r;
  assign tie          = tie_r;

endmodule

// File: tb/tb_dice_score_keeper.sv
// Scoreboard bench for dice_score_keeper: four configurations (free-for-all, strict turns,
// four players with a low target, narrow saturating score) driven by directed rolls.
module tb_dice_score_keeper;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // a: 2 players free-for-all, t: 2 players strict turns,
  // f: 4 players target 10, s: 2 players 4-bit scores target 15
  logic start_a_n, start_t_n, start_f_n, start_s_n;
  logic [1:0]  roll_a_n, roll_t_n, roll_s_n;
  logic [3:0]  roll_f_n;
  logic [5:0]  face_a, face_t, face_s;
  logic [11:0] face_f;
  logic [1:0]  fv_a, fv_t, fv_s, ill_a, ill_t, ill_s;
  logic [3:0]  fv_f, ill_f;
  logic [15:0] scores_a, scores_t;
  logic [31:0] scores_f;
  logic [7:0]  scores_s;
  logic [0:0]  turn_a, turn_t, turn_s, win_a, win_t, win_s;
  logic [1:0]  turn_f, win_f;
  logic        go_a, go_t, go_f, go_s, tie_a, tie_t, tie_f, tie_s;

  dice_score_keeper #(.NUM_PLAYERS(2), .TURN_MODE(0)) u_a (
    .clk(clk), .reset(reset), .start_n(start_a_n), .roll_n(roll_a_n), .face(face_a),
    .face_valid(fv_a), .scores(scores_a), .turn(turn_a), .illegal_roll(ill_a),
    .game_over(go_a), .winner(win_a), .tie(tie_a));
  dice_score_keeper #(.NUM_PLAYERS(2), .TURN_MODE(1)) u_t (
    .clk(clk), .reset(reset), .start_n(start_t_n), .roll_n(roll_t_n), .face(face_t),
    .face_valid(fv_t), .scores(scores_t), .turn(turn_t), .illegal_roll(ill_t),
    .game_over(go_t), .winner(win_t), .tie(tie_t));
  dice_score_keeper #(.NUM_PLAYERS(4), .TARGET(10), .TURN_MODE(0)) u_f (
    .clk(clk), .reset(reset), .start_n(start_f_n), .roll_n(roll_f_n), .face(face_f),
    .face_valid(fv_f), .scores(scores_f), .turn(turn_f), .illegal_roll(ill_f),
    .game_over(go_f), .winner(win_f), .tie(tie_f));
  dice_score_keeper #(.NUM_PLAYERS(2), .SCORE_W(4), .TARGET(15), .TURN_MODE(0)) u_s (
    .clk(clk), .reset(reset), .start_n(start_s_n), .roll_n(roll_s_n), .face(face_s),
    .face_valid(fv_s), .scores(scores_s), .turn(turn_s), .illegal_roll(ill_s),
    .game_over(go_s), .winner(win_s), .tie(tie_s));

  typedef struct {
    int inst; int player; int face; int score; int go; int win; int tie;
  } exp_t;

  exp_t q_a[$], q_t[$], q_f[$], q_s[$];
  int tests = 0;
  int fails = 0;

  int np   [4] = '{2, 2, 4, 2};
  int mode [4] = '{0, 1, 0, 0};
  int tgt  [4] = '{100, 100, 10, 15};
  int smax [4] = '{255, 255, 255, 15};
  int msc  [4][8];
  bit mplay[4];
  int mturn[4];

  int die_m;
  int nfv_a = 0, nfv_t = 0, nfv_f = 0, nfv_s = 0, nill_t0 = 0, nill_t1 = 0, nill_any = 0;

  // Reference die: starts at 1 and steps 1..6 on every edge
  always @(posedge clk or negedge reset) begin
    if (!reset) die_m <= 1;
    else        die_m <= (die_m == 6) ? 1 : die_m + 1;
  end

  function automatic int wrap6(input int x);
    return ((x - 1) % 6) + 1;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input exp_t e);
    case (e.inst)
      0: q_a.push_back(e);
      1: q_t.push_back(e);
      2: q_f.push_back(e);
      default: q_s.push_back(e);
    endcase
  endtask

  task automatic sb_check(input int inst, input int p, input int f, input int sc,
                          input int go, input int w, input int ti);
    exp_t e;
    bit   ok;
    ok = 1'b1;
    case (inst)
      0: if (q_a.size() == 0) ok = 1'b0; else e = q_a.pop_front();
      1: if (q_t.size() == 0) ok = 1'b0; else e = q_t.pop_front();
      2: if (q_f.size() == 0) ok = 1'b0; else e = q_f.pop_front();
      default: if (q_s.size() == 0) ok = 1'b0; else e = q_s.pop_front();
    endcase
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL sb_unexpected: inst %0d player %0d face %0d score %0d, expected no roll",
               inst, p, f, sc);
    end else begin
      check("sb_player", p, e.player);
      check("sb_face", f, e.face);
      check("sb_face_range", (f >= 1 && f <= 6) ? 1 : 0, 1);
      check("sb_score", sc, e.score);
      check("sb_game_over", go, e.go);
      check("sb_winner", w, e.win);
      check("sb_tie", ti, e.tie);
    end
  endtask

  // Monitor: every face_valid pulse is matched against the head of its scoreboard queue
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (fv_a[p]) sb_check(0, p, face_a[3*p +: 3], scores_a[8*p +: 8], go_a, win_a, tie_a);
      if (fv_t[p]) sb_check(1, p, face_t[3*p +: 3], scores_t[8*p +: 8], go_t, win_t, tie_t);
      if (fv_s[p]) sb_check(3, p, face_s[3*p +: 3], scores_s[4*p +: 4], go_s, win_s, tie_s);
    end
    for (int p = 0; p < 4; p++) begin
      if (fv_f[p]) sb_check(2, p, face_f[3*p +: 3], scores_f[8*p +: 8], go_f, win_f, tie_f);
    end
  end

  // Pulse counters
  always @(negedge clk) begin
    nfv_a    <= nfv_a + $countones(fv_a);
    nfv_t    <= nfv_t + $countones(fv_t);
    nfv_f    <= nfv_f + $countones(fv_f);
    nfv_s    <= nfv_s + $countones(fv_s);
    nill_t0  <= nill_t0 + (ill_t[0] ? 1 : 0);
    nill_t1  <= nill_t1 + (ill_t[1] ? 1 : 0);
    nill_any <= nill_any + $countones(ill_a) + $countones(ill_f) + $countones(ill_s);
  end

  task automatic drive_roll(input int inst, input logic [7:0] m);
    case (inst)
      0: roll_a_n = ~m[1:0];
      1: roll_t_n = ~m[1:0];
      2: roll_f_n = ~m[3:0];
      default: roll_s_n = ~m[1:0];
    endcase
  endtask

  task automatic drive_start(input int inst, input logic lvl);
    case (inst)
      0: start_a_n = lvl;
      1: start_t_n = lvl;
      2: start_f_n = lvl;
      default: start_s_n = lvl;
    endcase
  endtask

  task automatic start_game(input int inst);
    mplay[inst] = 1'b1;
    mturn[inst] = 0;
    for (int p = 0; p < 8; p++) msc[inst][p] = 0;
    drive_start(inst, 1'b0);
    repeat (2) @(negedge clk);
    drive_start(inst, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  // Waits until the die will show 'want' when the press is sampled, then presses 'mask'.
  task automatic roll(input int inst, input int mask, input int want, input int hold);
    int         n, hits, win, any;
    bit         acc[8];
    exp_t       e;
    logic [7:0] m;
    m = 8'(mask);
    n = 0;
    while (wrap6(die_m + 2) != want && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (n >= 12) begin
      tests++;
      fails++;
      $display("FAIL die_wait: face %0d never lined up for inst %0d", want, inst);
    end
    hits = 0; win = 0; any = 0;
    for (int p = 0; p < np[inst]; p++) begin
      acc[p] = 1'b0;
      if (m[p] && mplay[inst] && (mode[inst] == 0 || mturn[inst] == p)) begin
        acc[p] = 1'b1;
        any = 1;
        msc[inst][p] = (msc[inst][p] + want > smax[inst]) ? smax[inst] : msc[inst][p] + want;
        if (msc[inst][p] >= tgt[inst]) begin
          if (hits == 0) win = p;
          hits++;
        end
      end
    end
    for (int p = 0; p < np[inst]; p++) begin
      if (acc[p]) begin
        e.inst = inst; e.player = p; e.face = want; e.score = msc[inst][p];
        e.go = (hits > 0) ? 1 : 0; e.win = (hits > 0) ? win : 0; e.tie = (hits > 1) ? 1 : 0;
        push_exp(e);
      end
    end
    if (mode[inst] == 1 && any == 1) mturn[inst] = (mturn[inst] + 1) % np[inst];
    if (hits > 0) mplay[inst] = 1'b0;
    drive_roll(inst, m);
    repeat (hold) @(negedge clk);
    drive_roll(inst, 8'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    start_a_n = 1'b1; start_t_n = 1'b1; start_f_n = 1'b1; start_s_n = 1'b1;
    roll_a_n = 2'b11; roll_t_n = 2'b11; roll_f_n = 4'b1111; roll_s_n = 2'b11;
    for (int i = 0; i < 4; i++) begin
      mplay[i] = 1'b0;
      mturn[i] = 0;
    end
    repeat (3) @(negedge clk);
    check("rst_scores_a", scores_a, 0);
    check("rst_face_f", face_f, 0);
    check("rst_fv_f", fv_f, 0);
    check("rst_turn_t", turn_t, 0);
    check("rst_go_s", go_s, 0);
    check("rst_win_f", win_f, 0);
    check("rst_tie_f", tie_f, 0);
    check("rst_ill_t", ill_t, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Free-for-all: a roll in IDLE is ignored, then one 10-cycle hold is one roll
    roll(0, 1, 4, 3);
    check("a_idle_no_roll", nfv_a, 0);
    start_game(0);
    roll(0, 1, 4, 10);
    check("a_one_pulse", nfv_a, 1);
    check("a_score0", scores_a[7:0], 4);
    check("a_face0", face_a[2:0], 4);
    check("a_score1", scores_a[15:8], 0);

    // Strict turns
    start_game(1);
    roll(1, 2, 3, 2);
    check("t_illegal1", nill_t1, 1);
    check("t_illegal0", nill_t0, 0);
    check("t_no_accept", scores_t, 0);
    check("t_turn0", turn_t, 0);
    roll(1, 1, 5, 2);
    check("t_score0", scores_t[7:0], 5);
    check("t_turn1", turn_t, 1);
    roll(1, 2, 2, 2);
    check("t_score1", scores_t[15:8], 2);
    check("t_turn_wrap", turn_t, 0);
    roll(1, 3, 1, 2);
    check("t_both_score0", scores_t[7:0], 6);
    check("t_both_score1", scores_t[15:8], 2);
    check("t_both_illegal1", nill_t1, 2);
    check("t_turn_after_both", turn_t, 1);

    // Four players, target 10
    start_game(2);
    roll(2, 15, 3, 2);
    check("f_four_pulses", nfv_f, 4);
    check("f_scores_all3", scores_f, 32'h03030303);
    check("f_turn_ffa", turn_f, 0);
    roll(2, 1, 6, 2);
    check("f_score0_9", scores_f[7:0], 9);
    roll(2, 1, 2, 2);
    check("f_score0_11", scores_f[7:0], 11);
    check("f_game_over", go_f, 1);
    check("f_winner0", win_f, 0);
    check("f_no_tie", tie_f, 0);
    roll(2, 1, 5, 2);
    check("f_frozen_score", scores_f[7:0], 11);
    check("f_frozen_face", face_f[2:0], 2);
    check("f_no_pulse_done", nfv_f, 6);
    start_game(2);
    check("f_restart_go", go_f, 0);
    check("f_restart_scores", scores_f, 0);
    roll(2, 5, 4, 2);
    roll(2, 5, 4, 2);
    check("f_at_8", scores_f, 32'h00080008);
    roll(2, 5, 2, 2);
    check("f_tie_go", go_f, 1);
    check("f_tie_winner", win_f, 0);
    check("f_tie_flag", tie_f, 1);
    check("f_tie_score2", scores_f[23:16], 10);
    check("f_tie_score1", scores_f[15:8], 0);
    start_game(2);
    check("f_restart_tie", tie_f, 0);

    // 4-bit saturating scores, target 15
    start_game(3);
    roll(3, 1, 6, 2);
    roll(3, 1, 6, 2);
    roll(3, 1, 2, 2);
    check("s_score14", scores_s[3:0], 14);
    roll(3, 1, 6, 2);
    check("s_saturated", scores_s[3:0], 15);
    check("s_game_over", go_s, 1);

    // Asynchronous reset between clock edges
    #5;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) mplay[i] = 1'b0;
    #1;
    check("async_scores_s", scores_s, 0);
    check("async_go_s", go_s, 0);
    check("async_face_s", face_s, 0);
    check("async_face_f", face_f, 0);
    check("async_turn_t", turn_t, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    roll(3, 1, 3, 2);
    check("s_idle_after_reset", nfv_s, 4);
    check("s_score_idle", scores_s, 0);

    check("no_stray_illegal", nill_any, 0);
    check("queues_drained", q_a.size() + q_t.size() + q_f.size() + q_s.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dice_score_keeper.md
Name: dice_score_keeper

Overview:
- Parametrised N-player dice roll and score engine; successor to the fixed two-player key/score logic in the dice game top level.
- Per-player roll keys are synchronised and edge-detected, then sampled against free-running die counters.
- Rolls accumulate into saturating per-player scores; game end is declared at a programmable target, with winner and tie reporting.
- Optional strict turn-taking mode; outputs feed BCD/seven-segment and VGA face rendering.

Parameters:
- NUM_PLAYERS, 2, number of players (2..8).
- SCORE_W, 8, width of each score accumulator.
- TARGET, 100, score at or above which the game ends (must be < 2^SCORE_W).
- DIE_FACES, 6, die face count (2..7); faces run 1..DIE_FACES.
- TURN_MODE, 0, 0 = free-for-all, 1 = strict round-robin turns.
- Localparam PW = max(1, clog2(NUM_PLAYERS)).

Ports:
- clk  in  1  system clock (50 MHz domain).
- reset  in  1  asynchronous active-low reset.
- start_n  in  1  raw active-low new-game key.
- roll_n  in  NUM_PLAYERS  raw active-low roll keys; bit i belongs to player i.
- face  out  3*NUM_PLAYERS  last accepted face per player; slice i = bits [3i+2:3i].
- face_valid  out  NUM_PLAYERS  one-cycle pulse per player on an accepted roll.
- scores  out  SCORE_W*NUM_PLAYERS  score per player; slice i = bits [SCORE_W*i +: SCORE_W].
- turn  out  PW  player whose turn it is (TURN_MODE=1); held at 0 when TURN_MODE=0.
- illegal_roll  out  NUM_PLAYERS  one-cycle pulse when an out-of-turn roll is rejected.
- game_over  out  1  high in DONE state.
- winner  out  PW  index of the winning player; valid while game_over is high.
- tie  out  1  high when more than one player reached TARGET in the same cycle.

Behaviour:
- Reset (asynchronous, active-low) sets every output to 0:
  - face = 0, face_valid = 0, scores = 0, turn = 0, illegal_roll = 0, game_over = 0, winner = 0, tie = 0.
  - State goes to IDLE.
  - All synchroniser flops are set to 1 (released key level).
  - Die counters are set to 1.
- Input conditioning:
  - Each of start_n and roll_n[i] passes through a 2-flop synchroniser, plus one delay flop for edge detection.
  - A press is detected on the synchronised 1->0 transition.
  - Holding a key low produces exactly one press.
- Latency: if roll_n goes low before rising edge k, the score, face and face_valid update on edge k+2.
- Die counters: one per player.
  - Advances on every clock edge: 1, 2, ..., DIE_FACES, 1, ...
  - Runs in all states.
  - Sampled value is the counter output in the cycle the press is detected.
- FSM states:
  - IDLE:
    - Roll presses are ignored, with no illegal_roll pulse.
    - A start press moves to PLAY with scores cleared.
  - PLAY:
    - An accepted roll sets face[i] to the sampled value and pulses face_valid[i].
    - It also sets scores[i] to min(scores[i] + face, 2^SCORE_W - 1).
  - TURN_MODE=0 (free-for-all):
    - All simultaneous presses are accepted in the same cycle.
  - TURN_MODE=1 (strict turns):
    - Only a press from player `turn` is accepted.
    - After an accepted roll, turn advances: NUM_PLAYERS-1 wraps to 0.
    - Presses from other players are discarded and pulse illegal_roll[j].
    - A rejected press alongside an accepted press is still rejected.
  - End condition:
    - If any updated score is >= TARGET, the state moves to DONE on the same edge as the score update.
    - winner = lowest index that reached TARGET.
    - tie = 1 if two or more players crossed TARGET on that edge.
  - DONE:
    - game_over = 1.
    - Rolls are ignored with no pulses; faces and scores are frozen.
    - A start press clears scores, faces, turn, winner, tie and game_over, then moves to PLAY.
  - A start press in PLAY restarts the game: same clearing as from DONE, and any roll in the same cycle is dropped.
- Saturation: a score never wraps. A saturated score that is still below TARGET (only possible with a misconfigured TARGET) keeps the game in PLAY.
- Reset asserted mid-game forces the IDLE reset values immediately, with no clock needed.

Test Plan:
- Reset, release, pulse start_n, then hold roll_n[0] low for 10 cycles -> exactly one face_valid[0] pulse; face[0] is in 1..6 and equals the bench die model; scores[0] = face[0]; a 10-cycle hold gives no second roll.
- TURN_MODE=1: player 1 presses first -> illegal_roll[1] pulses and scores unchanged. Player 0 press -> accepted and turn = 1. Player 1 press -> accepted and turn = 0 (wrap).
- TURN_MODE=0, NUM_PLAYERS=4: all four keys pressed on the same cycle -> four face_valid pulses on one edge; each score += its own sampled face.
- TARGET=10, roll player 0 until its score >= 10 -> game_over = 1 on the same edge, winner = 0; later presses cause no change. Start press -> scores = 0, state PLAY.
- TARGET=10, players 0 and 2 both at 8, pressed together with faces >= 2 -> winner = 0, tie = 1.
- SCORE_W=4, TARGET=15: player at 14 rolls a 6 -> score saturates at 15 and game_over = 1. Assert reset mid-game -> all outputs 0 asynchronously and state IDLE.
